// File: rtl/arbitro_vc.sv
// Two-VC to two-destination arbiter: combinational pops, registered pushes and transfer count.
// Define ARB_ROUND_ROBIN_EN for round-robin between VCs; default build is strict VC0 priority.
module arbitro_vc #(
   parameter int DATA_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              vc0_empty,
   input  logic              vc1_empty,
   input  logic [DATA_W-1:0] vc0_data,
   input  logic [DATA_W-1:0] vc1_data,
   input  logic              d0_almost_full,
   input  logic              d1_almost_full,
   output logic              pop_vc0,
   output logic              pop_vc1,
   output logic              push_d0,
   output logic              push_d1,
   output logic [DATA_W-1:0] data_out,
   output logic [7:0]        xfer_count
);

   typedef enum logic [1:0] {IDLE, LAST0, LAST1} state_t;

   state_t            state;
   logic              last_vc;
   logic              elig0;
   logic              elig1;
   logic              grant0;
   logic              grant1;
   logic [DATA_W-1:0] grant_word;

   // Bit 4 of a head word selects its destination FIFO.
   function automatic logic dest_blocked(input logic [DATA_W-1:0] word,
                                         input logic af0, input logic af1);
      return word[4] ? af1 : af0;
   endfunction

   always_comb begin
      elig0 = enable & ~vc0_empty & ~dest_blocked(vc0_data, d0_almost_full, d1_almost_full);
      elig1 = enable & ~vc1_empty & ~dest_blocked(vc1_data, d0_almost_full, d1_almost_full);
`ifdef ARB_ROUND_ROBIN_EN
      grant0 = elig0 & (~elig1 | last_vc);
`else
      grant0 = elig0;
`endif
      grant1     = elig1 & ~grant0;
      grant_word = grant1 ? vc1_data : vc0_data;
      // Pops are forced low the instant reset asserts, not just at the next edge.
      pop_vc0    = grant0 & reset;
      pop_vc1    = grant1 & reset;
   end

`ifdef ARB_ROUND_ROBIN_EN
   logic unused_arb_state;
   assign unused_arb_state = ^state;
`else
   logic unused_arb_state;
   assign unused_arb_state = ^{state, last_vc};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_vc    <= 1'b1;
         push_d0    <= 1'b0;
         push_d1    <= 1'b0;
         data_out   <= '0;
         xfer_count <= '0;
      end else begin
         push_d0 <= 1'b0;
         push_d1 <= 1'b0;
         if (grant0 | grant1) begin
            data_out   <= grant_word;
            push_d0    <= ~grant_word[4];
            push_d1    <= grant_word[4];
            xfer_count <= xfer_count + 8'd1;
         end
         // Idle cycles keep last_vc so round-robin fairness survives gaps.
         if (grant0) begin
            state   <= LAST0;
            last_vc <= 1'b0;
         end else if (grant1) begin
            state   <= LAST1;
            last_vc <= 1'b1;
         end else begin
            state   <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_arbitro_vc.sv
// Randomized and directed bench for arbitro_vc against a cycle-level transfer model.
// Honours ARB_ROUND_ROBIN_EN the same way as the design.
module tb_arbitro_vc;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       vc0_empty = 1'b1;
   logic       vc1_empty = 1'b1;
   logic [5:0] vc0_data = '0;
   logic [5:0] vc1_data = '0;
   logic       d0_almost_full = 1'b0;
   logic       d1_almost_full = 1'b0;
   logic       pop_vc0, pop_vc1, push_d0, push_d1;
   logic [5:0] data_out;
   logic [7:0] xfer_count;

   arbitro_vc dut (
      .clk(clk), .reset(reset), .enable(enable),
      .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
      .vc0_data(vc0_data), .vc1_data(vc1_data),
      .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
      .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
      .push_d0(push_d0), .push_d1(push_d1),
      .data_out(data_out), .xfer_count(xfer_count)
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   int         last_vc = 1;
   int         last_g = -1;
   int         exp_cnt = 0;
   logic       exp_p0 = 1'b0;
   logic       exp_p1 = 1'b0;
   logic [5:0] exp_data = '0;
   int         seq[4];
   int         exp_seq[4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Which VC the arbiter should grant this cycle: -1 none, 0 or 1.
   function automatic int model_grant();
      bit e0, e1;
      e0 = enable && !vc0_empty && !(vc0_data[4] ? d1_almost_full : d0_almost_full);
      e1 = enable && !vc1_empty && !(vc1_data[4] ? d1_almost_full : d0_almost_full);
      if (e0 && e1) return (RR && last_vc == 0) ? 1 : 0;
      if (e0) return 0;
      if (e1) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      last_vc  = 1;
      exp_p0   = 1'b0;
      exp_p1   = 1'b0;
      exp_data = '0;
      exp_cnt  = 0;
   endtask

   task automatic check_regs();
      check("push_d0", push_d0, exp_p0);
      check("push_d1", push_d1, exp_p1);
      check("data_out", data_out, exp_data);
      check("xfer_count", xfer_count, exp_cnt);
   endtask

   // One clock: check pops mid-cycle, advance model at the edge, check registers after it.
   task automatic step();
      int g;
      @(negedge clk);
      g = model_grant();
      check("pop_vc0", pop_vc0, g == 0);
      check("pop_vc1", pop_vc1, g == 1);
      @(posedge clk);
      if (g >= 0) begin
         exp_data = (g == 0) ? vc0_data : vc1_data;
         exp_p0   = !exp_data[4];
         exp_p1   = exp_data[4];
         exp_cnt  = (exp_cnt + 1) % 256;
         last_vc  = g;
      end else begin
         exp_p0 = 1'b0;
         exp_p1 = 1'b0;
      end
      last_g = g;
      #1 check_regs();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1 check_regs();
      check("rst_pop", {pop_vc0, pop_vc1}, 2'b00);
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic set_in(input logic en, input logic e0, input logic e1,
                         input logic [5:0] d0, input logic [5:0] d1,
                         input logic af0, input logic af1);
      enable = en; vc0_empty = e0; vc1_empty = e1;
      vc0_data = d0; vc1_data = d1;
      d0_almost_full = af0; d1_almost_full = af1;
   endtask

   initial begin
      // Reset held with traffic present, then enable low.
      set_in(1'b1, 1'b0, 1'b0, 6'h03, 6'h13, 1'b0, 1'b0);
      #1 check_regs();
      check("rst_pop", {pop_vc0, pop_vc1}, 2'b00);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      enable = 1'b0;
      repeat (3) step();
      check("s1_count", xfer_count, 0);

      // Single transfer to D1.
      set_in(1'b1, 1'b0, 1'b1, 6'b010101, 6'h00, 1'b0, 1'b0);
      step();
      check("s2_grant", last_g, 0);
      check("s2_push_d1", push_d1, 1);
      check("s2_data", data_out, 6'b010101);
      check("s2_count", xfer_count, 1);
      vc0_empty = 1'b1;
      step();

      // Both VCs contending for D0.
      apply_reset();
      set_in(1'b1, 1'b0, 1'b0, 6'h03, 6'h05, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         seq[i] = last_g;
         exp_seq[i] = RR ? (i % 2) : 0;
      end
      for (int i = 0; i < 4; i++) check("s3_seq", seq[i], exp_seq[i]);

      // VC0 blocked by D0 almost-full, VC1 proceeds to D1.
      set_in(1'b1, 1'b0, 1'b0, 6'h05, 6'h13, 1'b1, 1'b0);
      step();
      check("s4_grant", last_g, 1);
      check("s4_push_d1", push_d1, 1);
      set_in(1'b1, 1'b0, 1'b0, 6'h05, 6'h13, 1'b1, 1'b1);
      step();
      check("s4_both_full", last_g, -1);

      // 256 back-to-back transfers wrap the counter, then enable drops after a grant.
      apply_reset();
      set_in(1'b1, 1'b0, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) begin
         vc0_data = 6'($urandom);
         step();
      end
      check("s5_wrap", xfer_count, 0);
      vc0_data = 6'h11;
      step();
      enable = 1'b0;
      #1 check("s5_push_held", push_d1, 1);
      check("s5_no_pop", pop_vc0, 0);
      step();
      check("s5_push_once", push_d1, 0);

      // Reset between the pop cycle and the push edge.
      set_in(1'b1, 1'b0, 1'b0, 6'h13, 6'h03, 1'b0, 1'b0);
      @(negedge clk);
      check("s6_pop", pop_vc0 | pop_vc1, 1);
      #1 reset = 1'b0;
      model_reset();
      #1 check("s6_pop_killed", {pop_vc0, pop_vc1}, 2'b00);
      @(posedge clk);
      #1 check_regs();
      @(posedge clk);
      #1 reset = 1'b1;
      step();
      check("s6_first_vc0", last_g, 0);

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         set_in(1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 99) < 30),
                1'($urandom_range(0, 99) < 30), 6'($urandom), 6'($urandom),
                1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 25));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/arbitro_vc.md
ARBITRO_VC -- requirements
Module: arbitro_vc

Interface
REQ-001 The block SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have port: enable  input  1  driven by the switch state machine's active_out; no new grant while low.
REQ-004 The block SHALL have ports: vc0_empty, vc1_empty  input  1 each  VC FIFO empty flags (show-ahead FIFOs, head valid when not empty).
REQ-005 The block SHALL have ports: vc0_data, vc1_data  input  6 each  VC FIFO head words; bit 4 = destination (0 -> D0, 1 -> D1).
REQ-006 The block SHALL have ports: d0_almost_full, d1_almost_full  input  1 each  destination FIFO almost-full flags.
REQ-007 The block SHALL have ports: pop_vc0, pop_vc1  output  1 each  combinational pop strobes to VC FIFOs.
REQ-008 The block SHALL have ports: push_d0, push_d1  output  1 each  registered push strobes to destination FIFOs.
REQ-009 The block SHALL have port: data_out  output  6  registered word for the destination FIFOs.
REQ-010 The block SHALL have port: xfer_count  output  8  registered count of completed transfers.

Function
REQ-011 eligible_i SHALL be enable AND NOT vci_empty AND NOT dX_almost_full, where X = vci_data[4].
REQ-012 At most one of pop_vc0/pop_vc1 SHALL be high in any cycle; pop_vci SHALL be high only when VCi is granted.
REQ-013 The FSM SHALL have states IDLE (no grant last cycle), LAST0 (VC0 granted last cycle), LAST1 (VC1 granted last cycle).
REQ-014 Transitions SHALL be: grant VC0 -> LAST0; grant VC1 -> LAST1; no grant -> IDLE, with the last-grant pointer retained.
REQ-015 Push latency SHALL be 1 cycle: on the edge ending a grant cycle, data_out <= granted head word, push_dX <= 1 for X = word bit 4, other push <= 0.
REQ-016 In a cycle with no grant, both push outputs SHALL be 0 on the following cycle, and data_out SHALL hold its value.
REQ-017 Throughput SHALL be one transfer per cycle when eligible.
REQ-018 xfer_count SHALL increment by 1 on every edge registering a push, wrapping 255 -> 0.
REQ-019 If enable falls while a push is registered, that push SHALL still appear; no new pop SHALL occur while enable = 0.
REQ-020 If the head's destination is almost-full, that VC SHALL be skipped without popping, and the other VC MAY be granted (no head-of-line blocking across VCs).
REQ-021 If both destination FIFOs are almost-full, no pop or push SHALL occur and the FSM SHALL go to IDLE.

Reset
REQ-022 While reset = 0, the block SHALL immediately force push_d0 = push_d1 = 0, pop_vc0 = pop_vc1 = 0, data_out = 0, xfer_count = 0, FSM = IDLE, last-grant pointer = VC1.
REQ-023 Reset asserted mid-transfer SHALL discard the pending registered push; the first grant after release SHALL favour VC0.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-025 With ARB_ROUND_ROBIN_EN defined, when both VCs are eligible, the VC not indicated by the last-grant pointer SHALL win.
REQ-026 With ARB_ROUND_ROBIN_EN undefined, when both VCs are eligible, VC0 SHALL always win (strict priority); FSM states and counting SHALL be unchanged.

Verification
REQ-027 Scenario 1: reset = 0 for 5 cycles, then 1, enable = 0, both VCs non-empty -> no pops, all outputs 0, xfer_count = 0.
REQ-028 Scenario 2: enable = 1, vc0_data = 6'b010101, vc1 empty, no almost-full -> pop_vc0 = 1 that cycle; next cycle push_d1 = 1, data_out = 6'b010101, xfer_count = 1.
REQ-029 Scenario 3: both VCs non-empty for 4 cycles, destination D0 -> with RR, grants VC0, VC1, VC0, VC1; without RR, grants VC0 x4.
REQ-030 Scenario 4: vc0 head bit4 = 0, d0_almost_full = 1, vc1 head bit4 = 1 -> pop_vc1 = 1, pop_vc0 = 0, push_d1 = 1 next cycle.
REQ-031 Scenario 5: 256 back-to-back transfers -> xfer_count wraps to 0; enable dropped right after the grant cycle -> the registered push still appears once.
REQ-032 Scenario 6: reset = 0 asserted between the pop cycle and the push edge -> push_d* never rises; after release with both VCs eligible, VC0 is granted first.
